// File: rtl/spi_sipo_rx_pkg.sv
// Shared types and constants for the SPI serial-in/parallel-out receiver.
// Used by spi_sipo_rx; SPI_SIPO_RX_PARITY_EN is handled in the files that use it.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        ARMED,
        SHIFT
    } rx_state_t;

    localparam logic SCLK_SYNC_RST = 1'b1;
    localparam logic CS_SYNC_RST   = 1'b1;
    localparam logic MOSI_SYNC_RST = 1'b0;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spi_sipo_rx_if.sv
// Valid/ready word stream leaving the SPI receiver.
// With SPI_SIPO_RX_PARITY_EN defined, the stream also carries the per-word out_perr flag.
interface spi_sipo_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
`ifdef SPI_SIPO_RX_PARITY_EN
    logic              out_perr;

    modport master (output out_data, output out_valid, output out_perr, input out_ready);
    modport slave  (input out_data, input out_valid, input out_perr, output out_ready);
`else
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/spi_sipo_rx_fifo.sv
// Small synchronous FIFO whose head is read straight from the storage flops.
// As a result, the head changes on the same edge as a pop, with no bubble cycle.
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO succeeds only when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/spi_sipo_rx.sv
// SPI receive front end: synchronises the SPI pins, deserialises words MSB first and queues them.
// SPI_SIPO_RX_PARITY_EN adds a trailing even-parity bit per word and the out_perr output.
module spi_sipo_rx
    import spi_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_in,
    input  logic cs_n_in,
    input  logic mosi_in,
    input  logic clr_flags,
    output logic overflow,
    output logic frame_err,
    output logic busy,
    spi_sipo_rx_if.master out_if
);
`ifdef SPI_SIPO_RX_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FIFO_W = DATA_W + PAR_W;
    localparam int CNT_W  = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1 + PAR_W);

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [1:0] settle;
    logic       sclk_d;
    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_rise;

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              frame_err_nxt;
    logic              push;
    logic [FIFO_W-1:0] push_data;
    logic              pop;
    logic [FIFO_W-1:0] head;
    logic              full;
    logic              empty;

    // settle keeps WAIT_IDLE from mistaking the synchronisers' reset value for an idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= {2{SCLK_SYNC_RST}};
            cs_sync   <= {2{CS_SYNC_RST}};
            mosi_sync <= {2{MOSI_SYNC_RST}};
            sclk_d    <= SCLK_SYNC_RST;
            settle    <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_in};
            cs_sync   <= {cs_sync[0], cs_n_in};
            mosi_sync <= {mosi_sync[0], mosi_in};
            sclk_d    <= sclk_s;
            settle    <= {settle[0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s && !sclk_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        frame_err_nxt = 1'b0;
        push          = 1'b0;
        push_data     = '0;
        case (state)
            WAIT_IDLE: begin
                if (settle[1] && cs_s) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!cs_s) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_nxt     = ARMED;
                    bit_cnt_nxt   = '0;
                    frame_err_nxt = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    if (bit_cnt == LAST_BIT) begin
                        push        = 1'b1;
                        bit_cnt_nxt = '0;
`ifdef SPI_SIPO_RX_PARITY_EN
                        // Even parity: an odd count of ones over data plus parity bit is an error.
                        push_data = {^{shift_reg, mosi_s}, shift_reg};
`else
                        push_data = {shift_reg[DATA_W-2:0], mosi_s};
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        shift_nxt   = {shift_reg[DATA_W-2:0], mosi_s};
                    end
                end
            end
            default: begin
                state_nxt = WAIT_IDLE;
            end
        endcase
    end

    assign pop = out_if.out_valid && out_if.out_ready;

    spi_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A dropped word outranks a clear arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_flags) begin
            overflow <= 1'b0;
        end
    end

    assign out_if.out_data  = head[DATA_W-1:0];
    assign out_if.out_valid = !empty;
`ifdef SPI_SIPO_RX_PARITY_EN
    assign out_if.out_perr  = head[DATA_W] && !empty;
`endif
    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_sipo_rx.sv
// Directed self-checking bench for spi_sipo_rx; inputs change and outputs are sampled on negedge clk.
// With SPI_SIPO_RX_PARITY_EN defined, each word is followed by its parity bit and out_perr is checked.
module tb_spi_sipo_rx;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    logic sclk_in;
    logic cs_n_in;
    logic mosi_in;
    logic clr_flags;
    logic overflow;
    logic frame_err;
    logic busy;
    logic last_bit;

    int tests_run = 0;
    int failures  = 0;
    int frame_err_cycles = 0;
    int err_base;
    logic [DATA_W-1:0] got [$];

    spi_sipo_rx_if #(.DATA_W(DATA_W)) stream_if ();

    spi_sipo_rx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk_in   (sclk_in),
        .cs_n_in   (cs_n_in),
        .mosi_in   (mosi_in),
        .clr_flags (clr_flags),
        .overflow  (overflow),
        .frame_err (frame_err),
        .busy      (busy),
        .out_if    (stream_if)
    );

    always #5 clk = ~clk;

    // Every accepted word and every cycle of frame_err is recorded for later checks.
    always @(posedge clk) begin
        if (stream_if.out_valid && stream_if.out_ready) got.push_back(stream_if.out_data);
        if (frame_err) frame_err_cycles++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_W-1:0] gotAt(int i);
        if (i < got.size()) return got[i];
        return 'x;
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(logic b);
        mosi_in = b;
        waitCycles(4);
        sclk_in = 1'b1;
        waitCycles(4);
        sclk_in = 1'b0;
    endtask

    task automatic applyStimulus(logic [31:0] word, int nbits);
        for (int i = nbits - 1; i >= 0; i--) sendBit(word[i]);
    endtask

    task automatic sendWord(logic [DATA_W-1:0] word);
        applyStimulus(32'(word), DATA_W);
`ifdef SPI_SIPO_RX_PARITY_EN
        sendBit(^word);
`endif
    endtask

    task automatic csLow();
        cs_n_in = 1'b0;
        waitCycles(4);
    endtask

    task automatic csHigh();
        cs_n_in = 1'b1;
        waitCycles(4);
    endtask

    initial begin
        reset = 1'b1;
        sclk_in = 1'b0;
        cs_n_in = 1'b1;
        mosi_in = 1'b0;
        clr_flags = 1'b0;
        stream_if.out_ready = 1'b0;
        waitCycles(3);
        checkOutput("reset_valid", 32'(stream_if.out_valid), 32'h0);
        checkOutput("reset_data", 32'(stream_if.out_data), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        waitCycles(5);

        // Single 0xA5 word with valid latency measured from the final SCLK rise.
        csLow();
        checkOutput("t1_busy", 32'(busy), 32'h1);
`ifdef SPI_SIPO_RX_PARITY_EN
        applyStimulus(32'hA5, 8);
        last_bit = 1'b0;
`else
        applyStimulus(32'h52, 7);
        last_bit = 1'b1;
`endif
        mosi_in = last_bit;
        waitCycles(4);
        sclk_in = 1'b1;
        waitCycles(2);
        checkOutput("t1_valid_edge2", 32'(stream_if.out_valid), 32'h0);
        waitCycles(1);
        checkOutput("t1_valid_edge3", 32'(stream_if.out_valid), 32'h1);
        checkOutput("t1_data", 32'(stream_if.out_data), 32'hA5);
        waitCycles(1);
        sclk_in = 1'b0;
        csHigh();
        checkOutput("t1_frame_err", 32'(frame_err_cycles), 32'h0);
        checkOutput("t1_data_stable", 32'(stream_if.out_data), 32'hA5);
        stream_if.out_ready = 1'b1;
        waitCycles(1);
        stream_if.out_ready = 1'b0;
        checkOutput("t1_valid_after_pop", 32'(stream_if.out_valid), 32'h0);
        checkOutput("t1_pop_word", 32'(gotAt(0)), 32'hA5);

        // Back-to-back words in one frame with the consumer always ready.
        got.delete();
        stream_if.out_ready = 1'b1;
        csLow();
        sendWord(8'h3C);
        sendWord(8'hFF);
        sendWord(8'h01);
        csHigh();
        checkOutput("t2_count", 32'(got.size()), 32'd3);
        checkOutput("t2_word0", 32'(gotAt(0)), 32'h3C);
        checkOutput("t2_word1", 32'(gotAt(1)), 32'hFF);
        checkOutput("t2_word2", 32'(gotAt(2)), 32'h01);

        // DEPTH+1 words with the consumer stalled: the fifth is dropped.
        got.delete();
        stream_if.out_ready = 1'b0;
        csLow();
        sendWord(8'h11);
        sendWord(8'h22);
        sendWord(8'h33);
        sendWord(8'h44);
        checkOutput("t3_no_overflow_yet", 32'(overflow), 32'h0);
        sendWord(8'h55);
        checkOutput("t3_overflow_set", 32'(overflow), 32'h1);
        csHigh();
        checkOutput("t3_overflow_sticky", 32'(overflow), 32'h1);
        checkOutput("t3_head", 32'(stream_if.out_data), 32'h11);
        clr_flags = 1'b1;
        waitCycles(1);
        clr_flags = 1'b0;
        checkOutput("t3_overflow_clr", 32'(overflow), 32'h0);
        stream_if.out_ready = 1'b1;
        waitCycles(8);
        checkOutput("t3_drained_valid", 32'(stream_if.out_valid), 32'h0);
        checkOutput("t3_count", 32'(got.size()), 32'd4);
        checkOutput("t3_word0", 32'(gotAt(0)), 32'h11);
        checkOutput("t3_word1", 32'(gotAt(1)), 32'h22);
        checkOutput("t3_word2", 32'(gotAt(2)), 32'h33);
        checkOutput("t3_word3", 32'(gotAt(3)), 32'h44);

        // Partial word then a clean frame.
        got.delete();
        err_base = frame_err_cycles;
        csLow();
        applyStimulus(32'h16, 5);
        cs_n_in = 1'b1;
        waitCycles(2);
        checkOutput("t4_ferr_edge2", 32'(frame_err), 32'h0);
        waitCycles(1);
        checkOutput("t4_ferr_edge3", 32'(frame_err), 32'h1);
        waitCycles(1);
        checkOutput("t4_ferr_edge4", 32'(frame_err), 32'h0);
        waitCycles(2);
        checkOutput("t4_ferr_width", 32'(frame_err_cycles - err_base), 32'd1);
        checkOutput("t4_busy_idle", 32'(busy), 32'h0);
        checkOutput("t4_no_partial_word", 32'(got.size()), 32'd0);
        csLow();
        sendWord(8'h81);
        csHigh();
        checkOutput("t4_count", 32'(got.size()), 32'd1);
        checkOutput("t4_word", 32'(gotAt(0)), 32'h81);
        checkOutput("t4_ferr_once", 32'(frame_err_cycles - err_base), 32'd1);

        // Reset mid-frame: the rest of the frame is ignored until CS_N cycles.
        got.delete();
        csLow();
        applyStimulus(32'h5, 3);
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        err_base = frame_err_cycles;
        applyStimulus(32'hC3, 8);
        waitCycles(2);
        checkOutput("t5_busy", 32'(busy), 32'h0);
        checkOutput("t5_valid", 32'(stream_if.out_valid), 32'h0);
        checkOutput("t5_no_word", 32'(got.size()), 32'd0);
        checkOutput("t5_no_ferr", 32'(frame_err_cycles - err_base), 32'd0);
        csHigh();
        csLow();
        sendWord(8'h5A);
        csHigh();
        checkOutput("t5_count", 32'(got.size()), 32'd1);
        checkOutput("t5_word", 32'(gotAt(0)), 32'h5A);

`ifdef SPI_SIPO_RX_PARITY_EN
        // 0x07 has three ones: parity bit 1 is correct, parity bit 0 is an error.
        stream_if.out_ready = 1'b0;
        csLow();
        applyStimulus(32'h00F, 9);
        csHigh();
        checkOutput("p_good_data", 32'(stream_if.out_data), 32'h07);
        checkOutput("p_good_perr", 32'(stream_if.out_perr), 32'h0);
        stream_if.out_ready = 1'b1;
        waitCycles(1);
        stream_if.out_ready = 1'b0;
        csLow();
        applyStimulus(32'h00E, 9);
        csHigh();
        checkOutput("p_bad_data", 32'(stream_if.out_data), 32'h07);
        checkOutput("p_bad_perr", 32'(stream_if.out_perr), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
